// File: rtl/pixel_uart_tx_pkg.sv
// Shared widths and serializer state encoding for the pixel-packing UART transmitter.
package pixel_uart_tx_pkg;

    localparam int UART_W      = 8;   // bits per UART character
    localparam int QUANTIZED_W = 2;   // bits kept per pixel after truncation
    localparam int PACK_NUM    = 4;   // quantized pixels per UART character

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART 8N1 serializer: accepts one byte when idle, then emits start, 8 data bits
// (LSB first) and stop, each 8*prescale_p cycles. The line and frame_done_o are
// registered from the current state, so the line trails the FSM by one cycle.
module uart_tx_serializer
    import pixel_uart_tx_pkg::*;
#(
    parameter int prescale_p = 27
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              valid_i,
    input  logic [UART_W-1:0] data_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              tx_serial_o,
    output logic              frame_done_o,
    output logic              active_o
);

    localparam int BIT_CYCLES = 8 * prescale_p;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W      = $clog2(UART_W);

    ser_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [UART_W-1:0]  shift;
    logic               last_flag;
    logic               bit_end;

    assign bit_end  = (cnt == CNT_W'(BIT_CYCLES - 1));
    assign ready_o  = (state == IDLE);
    assign active_o = (state != IDLE);

    // Serializer FSM with bit-period counter, shift register and registered line/pulse outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            last_flag    <= 1'b0;
            tx_serial_o  <= 1'b1;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_serial_o <= 1'b1;
                    if (valid_i) begin
                        shift     <= data_i;
                        last_flag <= last_i;
                        cnt       <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    tx_serial_o <= 1'b0;
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    tx_serial_o <= shift[0];
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == IDX_W'(UART_W - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx_serial_o <= 1'b1;
                    if (bit_end) begin
                        cnt          <= '0;
                        state        <= IDLE;
                        frame_done_o <= last_flag;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_serial_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pixel_uart_tx.sv
// Quantizes grayscale pixels, packs several per byte (slot 0 in the LSBs), holds one
// completed byte and hands it to the UART serializer so packing overlaps transmission.
module pixel_uart_tx
    import pixel_uart_tx_pkg::*;
#(
    parameter int prescale_p   = 27,
    parameter int unpacked_p   = QUANTIZED_W,
    parameter int num_packed_p = PACK_NUM
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [UART_W-1:0] data_i,
    input  logic              last_i,
    output logic              tx_serial_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int SLOT_W = (num_packed_p > 1) ? $clog2(num_packed_p) : 1;

    logic [SLOT_W-1:0]     slot;
    logic [UART_W-1:0]     pack;
    logic [UART_W-1:0]     byte_next;
    logic [UART_W-1:0]     hold_data;
    logic                  hold_valid;
    logic                  hold_last;
    logic [unpacked_p-1:0] q;
    logic                  accept;
    logic                  byte_done;
    logic                  ser_ready;
    logic                  ser_active;
    logic                  unused_low_bits;

    // Truncating quantizer keeps only the top bits; the rest are intentionally dropped.
    assign q               = data_i[UART_W-1 -: unpacked_p];
    assign unused_low_bits = ^data_i[UART_W-unpacked_p-1:0];

    assign ready_o   = !hold_valid;
    assign accept    = valid_i & ready_o;
    assign byte_done = (slot == SLOT_W'(num_packed_p - 1)) | last_i;
    assign busy_o    = hold_valid | ser_active;

    // Merge the current pixel into its slot of the partially packed byte
    always_comb begin
        byte_next = pack | (UART_W'(q) << (slot * unpacked_p));
    end

    // Slot counter, packing register and one-byte holding register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot       <= '0;
            pack       <= '0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            if (byte_done) begin
                hold_data  <= byte_next;
                hold_last  <= last_i;
                hold_valid <= 1'b1;
                pack       <= '0;
                slot       <= '0;
            end else begin
                pack <= byte_next;
                slot <= slot + SLOT_W'(1);
            end
        end else if (hold_valid && ser_ready) begin
            hold_valid <= 1'b0;
        end
    end

    uart_tx_serializer #(
        .prescale_p (prescale_p)
    ) u_serializer (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .valid_i      (hold_valid),
        .data_i       (hold_data),
        .last_i       (hold_last),
        .ready_o      (ser_ready),
        .tx_serial_o  (tx_serial_o),
        .frame_done_o (frame_done_o),
        .active_o     (ser_active)
    );

endmodule

// File: tb/tb_pixel_uart_tx.sv
// Scoreboard bench for pixel_uart_tx: stimulus pushes hand-computed bytes, a line
// monitor decodes the UART stream and pops/compares them, and checks frame_done timing.
module tb_pixel_uart_tx;

    localparam int PRESCALE = 3;
    localparam int BIT      = 8 * PRESCALE;

    logic       clk_i    = 1'b0;
    logic       reset_ni = 1'b0;
    logic       valid_i  = 1'b0;
    logic [7:0] data_i   = 8'h00;
    logic       last_i   = 1'b0;
    logic       ready_o;
    logic       tx_serial_o;
    logic       busy_o;
    logic       frame_done_o;

    always #5 clk_i = ~clk_i;

    pixel_uart_tx #(
        .prescale_p (PRESCALE)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .last_i       (last_i),
        .tx_serial_o  (tx_serial_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   fd_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   fd_count  = 0;
    int   last_gap  = 0;
    int   mon_start = 0;
    bit   mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Line monitor: decodes frames at mid-bit, checks edge phase, pops the scoreboard
    initial begin
        int         mon_cnt;
        int         high_run;
        int         k;
        logic       prev_tx;
        logic [7:0] mon_byte;
        exp_t       e;
        mon_cnt  = 0;
        high_run = 0;
        prev_tx  = 1'b1;
        mon_byte = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                mon_active = 1'b0;
                high_run   = 0;
                prev_tx    = 1'b1;
            end else begin
                if (frame_done_o) begin
                    fd_count++;
                    if (fd_q.size() == 0) check("frame_done_unexpected", 32'd1, 32'd0);
                    else check("frame_done_cycle", cyc, fd_q.pop_front());
                end
                if (mon_active) begin
                    mon_cnt++;
                    if (tx_serial_o !== prev_tx) check("level_edge_phase", mon_cnt % BIT, 0);
                    if (mon_cnt % BIT == BIT / 2) begin
                        k = mon_cnt / BIT;
                        if (k == 0) begin
                            check("start_bit", {31'd0, tx_serial_o}, 32'd0);
                        end else if (k <= 8) begin
                            mon_byte[k-1] = tx_serial_o;
                        end else begin
                            check("stop_bit", {31'd0, tx_serial_o}, 32'd1);
                            if (sb_q.size() == 0) begin
                                check("unexpected_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                            end else begin
                                e = sb_q.pop_front();
                                check("byte_data", {24'd0, mon_byte}, {24'd0, e.data});
                                if (e.last) fd_q.push_back(mon_start + 10 * BIT - 1);
                            end
                            $display("byte 0x%02h received at cycle %0d", mon_byte, cyc);
                            mon_active = 1'b0;
                        end
                    end
                end else if (tx_serial_o == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_start  = cyc;
                    last_gap   = high_run;
                end
                high_run = tx_serial_o ? high_run + 1 : 0;
                prev_tx  = tx_serial_o;
            end
        end
    end

    // Present one pixel and hold it until accepted; valid_i stays high afterwards
    task automatic send(input logic [7:0] d, input logic l);
        int guard;
        guard   = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!ready_o && guard < 20 * BIT) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (!ready_o) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        while ((busy_o || sb_q.size() != 0 || mon_active) && guard < 40 * BIT) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("drain_timeout", {31'd0, (guard >= 40 * BIT)}, 32'd0);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int low_seen;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_tx", {31'd0, tx_serial_o}, 32'd1);
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done_o}, 32'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Basic packing: C0,40,80,00 -> 0x27, plus start-bit latency from the handshake
        sb_q.push_back('{data: 8'h27, last: 1'b0});
        send(8'hC0, 1'b0);
        send(8'h40, 1'b0);
        send(8'h80, 1'b0);
        send(8'h00, 1'b0);
        valid_i = 1'b0;
        check("tx_after_handshake", {31'd0, tx_serial_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check("tx_one_cycle_after", {31'd0, tx_serial_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check("tx_fall_two_cycles", {31'd0, tx_serial_o}, 32'd0);
        drain();

        // Single pixel flagged last -> 0x03 and one frame_done pulse
        sb_q.push_back('{data: 8'h03, last: 1'b1});
        send(8'hFF, 1'b1);
        drain();
        check("frame_done_count_single", fd_count, 32'd1);

        // Eight pixels with valid held high -> two bytes, holding register back-pressure
        sb_q.push_back('{data: 8'h39, last: 1'b0});
        sb_q.push_back('{data: 8'h4F, last: 1'b0});
        send(8'h40, 1'b0);
        send(8'h80, 1'b0);
        send(8'hC0, 1'b0);
        send(8'h00, 1'b0);
        send(8'hC0, 1'b0);
        send(8'hC0, 1'b0);
        send(8'h00, 1'b0);
        send(8'h40, 1'b0);
        check("ready_low_while_held", {31'd0, ready_o}, 32'd0);
        check("busy_while_held", {31'd0, busy_o}, 32'd1);
        drain();
        check("idle_gap_between_frames", last_gap, BIT + 1);

        // 641-pixel frame -> 160 x 0xE4 then 0x03 carrying only slot 0
        for (int i = 0; i < 160; i++) sb_q.push_back('{data: 8'hE4, last: 1'b0});
        sb_q.push_back('{data: 8'h03, last: 1'b1});
        for (int i = 0; i < 640; i++) send(8'((i % 4) * 64), 1'b0);
        send(8'hC0, 1'b1);
        drain();
        check("frame_done_count_long", fd_count, 32'd2);

        // Reset during data bit 3 of a 0x00 byte, with two pixels partially packed
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'hC0, 1'b0);
        send(8'hC0, 1'b0);
        valid_i = 1'b0;
        guard = 0;
        while (!mon_active && guard < 10 * BIT) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("start_seen_timeout", {31'd0, mon_active}, 32'd1);
        guard = 0;
        while (cyc < mon_start + 4 * BIT + BIT / 2 && guard < 20 * BIT) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("tx_low_in_bit3", {31'd0, tx_serial_o}, 32'd0);
        reset_ni = 1'b0;
        #1;
        check("tx_high_on_reset", {31'd0, tx_serial_o}, 32'd1);
        check("ready_on_reset", {31'd0, ready_o}, 32'd1);
        check("busy_on_reset", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        low_seen = 0;
        repeat (3 * BIT) begin
            @(negedge clk_i);
            if (!tx_serial_o) low_seen++;
        end
        check("line_high_after_reset", low_seen, 32'd0);
        @(posedge clk_i);
        #1;
        sb_q.push_back('{data: 8'h36, last: 1'b0});
        send(8'h80, 1'b0);
        send(8'h40, 1'b0);
        send(8'hC0, 1'b0);
        send(8'h00, 1'b0);
        drain();

        check("scoreboard_empty", sb_q.size(), 32'd0);
        check("frame_done_queue_empty", fd_q.size(), 32'd0);
        check("frame_done_total", fd_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_uart_tx.md
PIXEL_UART_TX -- requirements
Module: pixel_uart_tx

Interface
REQ-001 SHALL have parameter prescale_p, default 27, meaning UART bit period = 8*prescale_p clk_i cycles (115200 baud at 25 MHz).
REQ-002 SHALL have parameter unpacked_p, default 2, meaning quantized pixel width in bits.
REQ-003 SHALL have parameter num_packed_p, default 4, meaning pixels per transmitted byte; unpacked_p*num_packed_p SHALL equal 8.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock for all state.
REQ-005 SHALL have port reset_ni, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i, input, 1, meaning pixel valid.
REQ-007 SHALL have port ready_o, output, 1, meaning pixel accepted when valid_i & ready_o at a rising clk_i edge.
REQ-008 SHALL have port data_i, input, 8, meaning unsigned grayscale pixel.
REQ-009 SHALL have port last_i, input, 1, meaning the accepted pixel is the final pixel of the frame.
REQ-010 SHALL have port tx_serial_o, output, 1, meaning UART 8N1 serial line, idle high.
REQ-011 SHALL have port busy_o, output, 1, meaning a byte is held or being serialized.
REQ-012 SHALL have port frame_done_o, output, 1, meaning one-cycle pulse at the end of the stop bit of the byte containing the last_i pixel.

Function
REQ-013 Quantization SHALL be q = data_i[7:8-unpacked_p] (truncation, no rounding).
REQ-014 Pixel k of a byte (k = 0..num_packed_p-1, acceptance order) SHALL occupy bits [2k+1:2k], so slot 0 is the LSBs.
REQ-015 A slot counter (0..num_packed_p-1) SHALL advance per accepted pixel and wrap to 0 when a byte completes.
REQ-016 A byte SHALL complete on acceptance of slot num_packed_p-1, or on acceptance of any pixel with last_i=1; unfilled slots SHALL be zero and the slot counter SHALL reset to 0.
REQ-017 A completed byte SHALL be written to a one-byte holding register (hold_valid=1) together with its last flag.
REQ-018 ready_o SHALL equal !hold_valid; it SHALL be combinational from registered state only, with no dependence on valid_i.
REQ-019 Serializer FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE with hold_valid=1 SHALL load the shift register, clear hold_valid, and enter START on the same edge.
REQ-021 START SHALL drive 0, DATA SHALL drive bits 0..7 LSB first, and STOP SHALL drive 1; each SHALL last exactly 8*prescale_p cycles.
REQ-022 STOP completion SHALL return to IDLE; if hold_valid=1 at that edge, the next START SHALL begin on the following cycle, giving exactly one idle-high cycle between frames.
REQ-023 tx_serial_o SHALL be registered; it SHALL fall 2 cycles after the handshake edge that completes a byte when the serializer is idle.
REQ-024 A new byte MAY complete into the holding register while the serializer is in START, DATA, or STOP, so pixel acceptance overlaps transmission.
REQ-025 busy_o SHALL equal hold_valid | (state != IDLE).
REQ-026 frame_done_o SHALL pulse exactly once per byte flagged last, on the STOP-to-IDLE transition.

Reset
REQ-027 On reset_ni=0 the block SHALL immediately force tx_serial_o=1, ready_o=1, busy_o=0, frame_done_o=0, state IDLE, slot counter 0, hold_valid 0.
REQ-028 Reset mid-byte SHALL discard partially packed pixels and any byte in flight without emitting a stop bit; the line SHALL stay high until new data arrives.
REQ-029 Reset SHALL be released synchronously to clk_i by the upstream reset synchronizer; no glitch on tx_serial_o at deassertion is permitted.

Structure
REQ-030 UART_W=8, QUANTIZED_W=2, PACK_NUM=4, and the serializer state enum SHALL reside in a shared package.
REQ-031 The START/DATA/STOP FSM, bit-period counter, and shift register SHALL be one sub-module, uart_tx_serializer, with valid/ready byte input.
REQ-032 Packing and holding logic SHALL reside in pixel_uart_tx.

Verification
REQ-033 Pixels 0xC0, 0x40, 0x80, 0x00 -> byte 0x27; line shows 0 then 1,1,1,0,0,1,0,0 then 1, each level 216 cycles.
REQ-034 Single pixel 0xFF with last_i=1 -> byte 0x03, then frame_done_o pulse one cycle after the stop bit ends.
REQ-035 641 pixels with last_i on the final pixel, valid_i held high -> 161 bytes; the final byte carries only slot 0; frame_done_o pulses exactly once.
REQ-036 Valid_i held high across 8 pixels -> ready_o drops while the second byte is held; no pixel is lost; exactly one idle-high cycle between the two frames.
REQ-037 reset_ni pulsed low during DATA bit 3 -> tx_serial_o high in the same cycle; the next 4 pixels after reset produce a clean, correct byte.
